set_assoc_wb_cache: RTL and testbench
=====================================

// Module: set_assoc_wb_cache
// PURPOSE
//  Parametrised N-way set-associative write-back, write-allocate byte cache with true-LRU replacement.
//  Sits between a byte-wide CPU req/resp port and a byte-per-beat backing-memory port.
//  Misses run real block fills, and dirty victims are written back before the fill.
// PARAMETERS
//  CACHE_SIZE  256  total data bytes; must equal NUM_SETS*ASSOC*BLOCK_SIZE
//  BLOCK_SIZE  16   bytes per line; power of 2, >=2
//  ASSOC       4    ways per set; power of 2, >=2
//  NUM_SETS    CACHE_SIZE/(BLOCK_SIZE*ASSOC)  sets; power of 2, >=1
//  Derived: OFF_W=$clog2(BLOCK_SIZE), IDX_W=$clog2(NUM_SETS), TAG_W=32-IDX_W-OFF_W
// PORTS
//  clk            in   1   single clock, rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  cpu_req        in   1   request valid
//  cpu_we         in   1   1=write, 0=read
//  cpu_addr       in   32  byte address
//  cpu_wdata      in   8   write byte
//  cpu_ready      out  1   high only in IDLE; request accepted when cpu_req&&cpu_ready
//  cpu_resp_valid out  1   1-cycle pulse that completes the accepted request
//  cpu_rdata      out  8   read byte, valid with cpu_resp_valid (0 for writes)
//  cpu_hit        out  1   1 if the request hit, valid with cpu_resp_valid
//  mem_req        out  1   memory beat request
//  mem_we         out  1   1=writeback beat, 0=fill beat
//  mem_addr       out  32  beat byte address
//  mem_wdata      out  8   writeback byte
//  mem_rdata      in   8   fill byte, sampled when mem_ack=1
//  mem_ack        in   1   completes the current beat
// BEHAVIOUR
//  Address split: tag=addr[31:IDX_W+OFF_W], idx=addr[IDX_W+OFF_W-1:OFF_W], off=addr[OFF_W-1:0].
//  Accept registers cpu_we, cpu_addr and cpu_wdata; the registered copies are used until the response.
//  FSM states: IDLE -> LOOKUP -> {RESPOND | WRITEBACK | FILL}; WRITEBACK -> FILL -> RESPOND -> IDLE.
//  LOOKUP compares the tags of all ways in set idx. A way hits when it is valid and its tag matches.
//   - Hit, read: cpu_rdata takes the cached byte.
//   - Hit, write: the byte is written, and dirty is set for that way.
//   - Either hit case: update LRU, then go to RESPOND.
//  Hit latency: accept in cycle N, cpu_resp_valid in cycle N+2, cpu_ready high again in N+3.
//  Miss, victim choice: the lowest-index invalid way; otherwise the way with age==ASSOC-1.
//  Miss, next state: WRITEBACK if the victim is valid and dirty, else FILL.
//  WRITEBACK streams BLOCK_SIZE beats:
//   - mem_we=1, mem_addr = {victim_tag, idx, beat}, mem_wdata = victim byte[beat].
//   - The beat counter advances only on mem_ack.
//   - mem_req stays high across beats; address and data are stable while mem_ack=0.
//  FILL streams BLOCK_SIZE beats:
//   - mem_we=0, mem_addr = {tag, idx, beat}; mem_rdata is written to the victim line on each ack.
//   - After the last ack: valid=1, tag is written, dirty=0.
//   - Write request: merge cpu_wdata at off and set dirty=1.
//   - Read request: cpu_rdata takes the filled byte at off.
//   - Update LRU, then go to RESPOND. cpu_hit=0 on every miss response.
//  mem_req falls in the cycle after the last ack of FILL. The WRITEBACK -> FILL handoff keeps mem_req high.
//  LRU: per-set age[way] of $clog2(ASSOC) bits. An access to way w increments every age < age[w]
//   and sets age[w]=0. Ages always stay a permutation of 0..ASSOC-1.
//  The beat counter wraps to 0 at BLOCK_SIZE-1. The address tag is never carried into idx.
//  cpu_req while busy: cpu_ready=0, so nothing is accepted. The requester holds its request.
//  Reset (asynchronous; also applies mid-operation):
//   - FSM=IDLE; all valid and dirty bits=0; age[s][w]=w.
//   - Outputs: cpu_ready=1; cpu_resp_valid, cpu_hit, cpu_rdata, mem_req, mem_we, mem_addr and mem_wdata all 0.
//   - Any in-flight memory transaction is abandoned.
//  Data and tag arrays are not reset.
// CONFIGURATION
//  CACHE_STATS_EN defined:
//   - Adds output ports stat_hits[31:0], stat_misses[31:0] and stat_writebacks[31:0].
//   - stat_hits / stat_misses increment at each RESPOND with cpu_hit=1 / cpu_hit=0.
//   - stat_writebacks increments once per completed WRITEBACK.
//   - The counters saturate at 32'hFFFF_FFFF and are cleared by reset_n.
//  CACHE_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.
// TESTING (default parameters: 4 sets, 4 ways, 16B lines; idx=addr[5:4])
//  1. Reset, then read 0x100 -> 16 fill beats at 0x100..0x10F, resp with cpu_hit=0 and cpu_rdata=mem[0x100].
//     Then read 0x105 -> resp at N+2 with cpu_hit=1, no mem_req.
//  2. Write 0x105=0xA5 (hit) -> no mem traffic; read 0x105 -> 0xA5 with cpu_hit=1.
//  3. Read 0x000, 0x040, 0x080, 0x0C0, then 0x000 again, then read 0x100.
//     -> Fill of 0x100 replaces the 0x040 line; a later read of 0x040 misses and a read of 0x000 hits.
//  4. Write 0x043=0x5C, then force eviction of 0x040's line.
//     -> 16 mem_we=1 beats at 0x040..0x04F, beat 3 carries 0x5C, followed by 16 fill beats.
//  5. Hold mem_ack=0 for 5 cycles mid-fill -> mem_req=1 with mem_addr unchanged; fill completes after ack resumes.
//  6. Assert reset_n=0 mid-fill -> all outputs 0 except cpu_ready=1; re-read the same address -> miss and full fill.

Source files
------------

// File: rtl/set_assoc_wb_cache.sv
// set_assoc_wb_cache: N-way set-associative, write-back, write-allocate byte cache
// with true-LRU replacement, byte-per-beat block fills and dirty-victim writeback.
// Optional feature macro: CACHE_STATS_EN adds saturating hit/miss/writeback counters.
// Handshakes: a CPU request is taken on a cycle with cpu_req && cpu_ready and is
// completed by a one-cycle cpu_resp_valid pulse; a memory beat is offered while
// mem_req is high and completes on the cycle mem_ack is high, with mem_we, mem_addr
// and mem_wdata held steady until then.
module set_assoc_wb_cache #(
    parameter int CACHE_SIZE = 256,
    parameter int BLOCK_SIZE = 16,
    parameter int ASSOC      = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_resp_valid,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_hit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
`ifdef CACHE_STATS_EN
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses,
    output logic [31:0] stat_writebacks,
`endif
    output logic [2:0]  dbg_state_o
);
    localparam int NUM_SETS = CACHE_SIZE / (BLOCK_SIZE * ASSOC);
    localparam int OFF_W    = $clog2(BLOCK_SIZE);
    localparam int IDX_W    = $clog2(NUM_SETS);
    localparam int TAG_W    = 32 - IDX_W - OFF_W;
    localparam int IDX_WS   = (IDX_W > 0) ? IDX_W : 1;
    localparam int WAY_W    = $clog2(ASSOC);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_RESPOND, S_WRITEBACK, S_FILL} state_e;

    state_e           state_q, state_d;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [7:0]       wdata_q;
    logic [WAY_W-1:0] victim_q;
    logic [OFF_W-1:0] beat_q;
    logic             hit_q;
    logic [7:0]       rdata_q;

    logic [7:0]       data_q  [NUM_SETS][ASSOC][BLOCK_SIZE];
    logic [TAG_W-1:0] tag_q   [NUM_SETS][ASSOC];
    logic [ASSOC-1:0] valid_q [NUM_SETS];
    logic [ASSOC-1:0] dirty_q [NUM_SETS];
    logic [WAY_W-1:0] age_q   [NUM_SETS][ASSOC];

    logic [TAG_W-1:0] req_tag;
    logic [IDX_WS-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic             hit_any;
    logic [WAY_W-1:0] hit_way, victim_c, lru_way;
    logic             last_beat, lru_en;

    // The masked shift keeps the set index inside range even for a single-set build.
    assign req_tag   = addr_q[31:IDX_W+OFF_W];
    assign req_idx   = IDX_WS'((addr_q >> OFF_W) & 32'(NUM_SETS - 1));
    assign req_off   = addr_q[OFF_W-1:0];
    assign last_beat = (beat_q == OFF_W'(BLOCK_SIZE - 1));
    assign lru_en    = (state_q == S_LOOKUP && hit_any) || (state_q == S_FILL && mem_ack && last_beat);
    assign lru_way   = (state_q == S_LOOKUP) ? hit_way : victim_q;

    assign cpu_ready      = (state_q == S_IDLE);
    assign cpu_resp_valid = (state_q == S_RESPOND);
    assign cpu_rdata      = rdata_q;
    assign cpu_hit        = hit_q;
    assign dbg_state_o    = state_q;

    // Tag compare across the set, and victim choice: lowest invalid way, else the oldest way.
    always_comb begin
        hit_any  = 1'b0;
        hit_way  = '0;
        victim_c = '0;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (age_q[req_idx][w] == WAY_W'(ASSOC - 1)) victim_c = WAY_W'(w);
        end
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) victim_c = WAY_W'(w);
        end
    end

    // Next-state logic of the request FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (cpu_req) state_d = S_LOOKUP;
            S_LOOKUP: begin
                if (hit_any)
                    state_d = S_RESPOND;
                else if (valid_q[req_idx][victim_c] && dirty_q[req_idx][victim_c])
                    state_d = S_WRITEBACK;
                else
                    state_d = S_FILL;
            end
            S_WRITEBACK: if (mem_ack && last_beat) state_d = S_FILL;
            S_FILL:      if (mem_ack && last_beat) state_d = S_RESPOND;
            S_RESPOND:   state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Memory beat outputs; the beat counter alone moves the address, so it only changes on ack.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == S_WRITEBACK) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = (32'(tag_q[req_idx][victim_q]) << (IDX_W + OFF_W))
                      | (32'(req_idx) << OFF_W) | 32'(beat_q);
            mem_wdata = data_q[req_idx][victim_q][beat_q];
        end else if (state_q == S_FILL) begin
            mem_req   = 1'b1;
            mem_addr  = (32'(req_tag) << (IDX_W + OFF_W)) | (32'(req_idx) << OFF_W) | 32'(beat_q);
        end
    end

    // Control state, response registers, valid/dirty bits and LRU ages.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            victim_q <= '0;
            beat_q   <= '0;
            hit_q    <= 1'b0;
            rdata_q  <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < ASSOC; w++) age_q[s][w] <= WAY_W'(w);
            end
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && cpu_req) begin
                we_q    <= cpu_we;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
            end
            case (state_q)
                S_LOOKUP: begin
                    victim_q <= victim_c;
                    beat_q   <= '0;
                    if (hit_any) begin
                        hit_q   <= 1'b1;
                        rdata_q <= we_q ? 8'h00 : data_q[req_idx][hit_way][req_off];
                        if (we_q) dirty_q[req_idx][hit_way] <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack) beat_q <= beat_q + OFF_W'(1);
                end
                S_FILL: begin
                    if (mem_ack) begin
                        beat_q <= beat_q + OFF_W'(1);
                        if (last_beat) begin
                            valid_q[req_idx][victim_q] <= 1'b1;
                            dirty_q[req_idx][victim_q] <= we_q;
                            hit_q <= 1'b0;
                            // The requested byte may be the one arriving on this very beat.
                            if (we_q)
                                rdata_q <= 8'h00;
                            else if (req_off == beat_q)
                                rdata_q <= mem_rdata;
                            else
                                rdata_q <= data_q[req_idx][victim_q][req_off];
                        end
                    end
                end
                default: ;
            endcase
            if (lru_en) begin
                for (int w = 0; w < ASSOC; w++) begin
                    if (age_q[req_idx][w] < age_q[req_idx][lru_way])
                        age_q[req_idx][w] <= age_q[req_idx][w] + WAY_W'(1);
                end
                age_q[req_idx][lru_way] <= '0;
            end
        end
    end

    // Data and tag arrays: fill beats, the CPU byte merged after the last fill beat, write hits.
    always_ff @(posedge clk) begin
        if (state_q == S_FILL && mem_ack) begin
            data_q[req_idx][victim_q][beat_q] <= mem_rdata;
            if (last_beat) begin
                tag_q[req_idx][victim_q] <= req_tag;
                if (we_q) data_q[req_idx][victim_q][req_off] <= wdata_q;
            end
        end
        if (state_q == S_LOOKUP && hit_any && we_q)
            data_q[req_idx][hit_way][req_off] <= wdata_q;
    end

`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits_q, stat_misses_q, stat_wb_q;

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
            stat_wb_q     <= '0;
        end else begin
            if (state_q == S_RESPOND && hit_q && stat_hits_q != '1)
                stat_hits_q <= stat_hits_q + 32'd1;
            if (state_q == S_RESPOND && !hit_q && stat_misses_q != '1)
                stat_misses_q <= stat_misses_q + 32'd1;
            if (state_q == S_WRITEBACK && mem_ack && last_beat && stat_wb_q != '1)
                stat_wb_q <= stat_wb_q + 32'd1;
        end
    end

    assign stat_hits       = stat_hits_q;
    assign stat_misses     = stat_misses_q;
    assign stat_writebacks = stat_wb_q;
`endif
endmodule

// File: tb/tb_set_assoc_wb_cache.sv
// tb_set_assoc_wb_cache: directed scenarios plus random traffic against a
// recency-timestamp cache model and a flat golden byte memory.
module tb_set_assoc_wb_cache;
    localparam int BS = 16;
    localparam int NS = 4;
    localparam int AS = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready, cpu_resp_valid, cpu_hit;
    logic [7:0]  cpu_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [2:0]  dbg_state;
`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits, stat_misses, stat_writebacks;
`endif

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    set_assoc_wb_cache dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
        .cpu_hit(cpu_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
`ifdef CACHE_STATS_EN
        .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_writebacks(stat_writebacks),
`endif
        .dbg_state_o(dbg_state)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem    [0:4095];   // backing store seen by the memory port
    logic [7:0]  golden [0:4095];   // what the CPU should observe
    logic [40:0] exp_q[$];          // expected beats {we, addr, wdata}
    logic [40:0] log_q[$];          // beats completed by the responder
    bit          stall = 1'b0;

    bit m_valid [NS][AS];
    int m_tag   [NS][AS];
    bit m_dirty [NS][AS];
    int m_stamp [NS][AS];
    int m_time;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int count_fill();
        int n = 0;
        foreach (log_q[i]) if (log_q[i][40] == 1'b0) n++;
        return n;
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (reset_n && mem_req && !stall && $urandom_range(0, 3) != 0) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem[mem_addr[11:0]] = mem_wdata;
                    mem_rdata = 8'h00;
                    log_q.push_back({1'b1, mem_addr, mem_wdata});
                end else begin
                    mem_rdata = mem[mem_addr[11:0]];
                    log_q.push_back({1'b0, mem_addr, 8'h00});
                end
            end else begin
                mem_ack = 1'b0;
                mem_rdata = 8'($urandom);
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < AS; k++) begin
                m_valid[s][k] = 1'b0;
                m_dirty[s][k] = 1'b0;
                m_stamp[s][k] = 0;
            end
        m_time = 0;
        for (int i = 0; i < 4096; i++) golden[i] = mem[i];
    endtask

    task automatic model_access(input logic we, input logic [31:0] addr, input logic [7:0] wd,
                                output bit hit, output logic [7:0] rd);
        int a, s, t, slot, base;
        a = int'(addr);
        s = (a / BS) % NS;
        t = a / (BS * NS);
        hit = 1'b0;
        slot = -1;
        for (int k = 0; k < AS; k++)
            if (m_valid[s][k] && m_tag[s][k] == t) begin hit = 1'b1; slot = k; end
        if (!hit) begin
            for (int k = 0; k < AS; k++) if (!m_valid[s][k] && slot < 0) slot = k;
            if (slot < 0) begin
                slot = 0;
                for (int k = 1; k < AS; k++) if (m_stamp[s][k] < m_stamp[s][slot]) slot = k;
                if (m_dirty[s][slot]) begin
                    base = m_tag[s][slot] * BS * NS + s * BS;
                    for (int i = 0; i < BS; i++) exp_q.push_back({1'b1, 32'(base + i), golden[base + i]});
                end
            end
            base = (a / BS) * BS;
            for (int i = 0; i < BS; i++) exp_q.push_back({1'b0, 32'(base + i), 8'h00});
            m_valid[s][slot] = 1'b1;
            m_tag[s][slot] = t;
            m_dirty[s][slot] = 1'b0;
        end
        if (we) begin
            golden[a] = wd;
            m_dirty[s][slot] = 1'b1;
            rd = 8'h00;
        end else begin
            rd = golden[a];
        end
        m_time++;
        m_stamp[s][slot] = m_time;
    endtask

    // ---------------- driver ----------------
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [7:0] wd);
        bit exp_hit, got;
        logic [7:0] exp_rd, rd;
        logic h;
        int lat;
        model_access(we, addr, wd, exp_hit, exp_rd);
        @(negedge clk);
        check_eq("ready_before", 64'(cpu_ready), 64'(1));
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk);
        lat = 0; got = 1'b0; rd = 8'h00; h = 1'b0;
        while (!got && lat < 2000) begin
            @(negedge clk);
            cpu_req = 1'b0;
            lat++;
            if (cpu_resp_valid) begin got = 1'b1; rd = cpu_rdata; h = cpu_hit; end
        end
        check_eq("resp_seen", 64'(got), 64'(1));
        check_eq("rdata", 64'(rd), 64'(exp_rd));
        check_eq("hit", 64'(h), 64'(exp_hit));
        if (exp_hit) check_eq("hit_latency", 64'(lat), 64'(2));
        @(negedge clk);
        check_eq("ready_after", 64'(cpu_ready), 64'(1));
        check_eq("beat_count", 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check_eq("beat", 64'(log_q[i]), 64'(exp_q[i]));
        exp_q.delete();
        log_q.delete();
    endtask

    task automatic stall_probe(input logic [31:0] base);
        bit ok = 1'b0;
        int n = 0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(posedge clk); #1;
            n = count_fill();
            if (n >= 5) ok = 1'b1;
        end
        check_eq("t5_reach", 64'(ok), 64'(1));
        if (ok) begin
            stall = 1'b1;
            repeat (5) begin
                @(posedge clk); #1;
                check_eq("t5_req", 64'(mem_req), 64'(1));
                check_eq("t5_we", 64'(mem_we), 64'(0));
                check_eq("t5_addr", 64'(mem_addr), 64'(base + 32'(n)));
            end
            check_eq("t5_no_beat", 64'(count_fill()), 64'(n));
            stall = 1'b0;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        logic [31:0] ra;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 64'(cpu_ready), 64'(1));
        check_eq("rst_resp", 64'(cpu_resp_valid), 64'(0));
        check_eq("rst_hit", 64'(cpu_hit), 64'(0));
        check_eq("rst_rdata", 64'(cpu_rdata), 64'(0));
        check_eq("rst_mem_req", 64'(mem_req), 64'(0));
        check_eq("rst_mem_we", 64'(mem_we), 64'(0));
        check_eq("rst_mem_addr", 64'(mem_addr), 64'(0));
        check_eq("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        reset_n = 1'b1;
        model_reset();

        // 1: cold miss then hit in the same line
        do_access(1'b0, 32'h100, 8'h00);
        do_access(1'b0, 32'h105, 8'h00);
        // 2: write hit then read back
        do_access(1'b1, 32'h105, 8'hA5);
        do_access(1'b0, 32'h105, 8'h00);
        // 3: LRU in set 0
        do_access(1'b0, 32'h000, 8'h00);
        do_access(1'b0, 32'h040, 8'h00);
        do_access(1'b0, 32'h080, 8'h00);
        do_access(1'b0, 32'h0C0, 8'h00);
        do_access(1'b0, 32'h000, 8'h00);
        do_access(1'b0, 32'h100, 8'h00);
        do_access(1'b0, 32'h040, 8'h00);
        do_access(1'b0, 32'h000, 8'h00);
        // 4: dirty line evicted by four new tags in set 0
        do_access(1'b1, 32'h043, 8'h5C);
        do_access(1'b0, 32'h200, 8'h00);
        do_access(1'b0, 32'h240, 8'h00);
        do_access(1'b0, 32'h280, 8'h00);
        do_access(1'b0, 32'h2C0, 8'h00);
        // 5: memory stall mid-fill on a clean miss in set 1
        fork
            do_access(1'b0, 32'h357, 8'h00);
            stall_probe(32'h350);
        join

        // 6: reset mid-fill, then a full refill of the same line
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1A0; cpu_wdata = 8'h00;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(posedge clk); #1;
            if (count_fill() >= 3) ok = 1'b1;
        end
        check_eq("t6_reach", 64'(ok), 64'(1));
        stall = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("t6_ready", 64'(cpu_ready), 64'(1));
        check_eq("t6_resp", 64'(cpu_resp_valid), 64'(0));
        check_eq("t6_hit", 64'(cpu_hit), 64'(0));
        check_eq("t6_rdata", 64'(cpu_rdata), 64'(0));
        check_eq("t6_mem_req", 64'(mem_req), 64'(0));
        check_eq("t6_mem_we", 64'(mem_we), 64'(0));
        check_eq("t6_mem_addr", 64'(mem_addr), 64'(0));
        check_eq("t6_mem_wdata", 64'(mem_wdata), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        stall = 1'b0;
        log_q.delete();
        exp_q.delete();
        model_reset();
        do_access(1'b0, 32'h1A0, 8'h00);

        // random traffic: a hot window for hits plus a wider range for conflicts
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 1) == 0) ra = 32'($urandom_range(0, 255));
            else ra = 32'($urandom_range(0, 1023));
            do_access(($urandom_range(0, 2) == 0), ra, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
